// File: rtl/arch_defs_pkg.sv
// ---------------------------------------------------------------------------
// arch_defs_pkg
// Machine-wide architectural constants for the SAP-2 system.
//   DATA_WIDTH : width of the CPU data bus seen by memory-mapped peripherals.
// ---------------------------------------------------------------------------
package arch_defs_pkg;

    localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the SAP-2 serial port.
//   parity_mode_t   : parity configuration (none / even / odd)
//   uart_rx_state_t : receiver frame-decoding states
//   RX_STAT_*       : bit positions inside the receiver status register
//   majority3       : 2-of-3 vote used when majority sampling is enabled
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_mode_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_rx_state_t;

    localparam int RX_STAT_FRAME   = 0;
    localparam int RX_STAT_PARITY  = 1;
    localparam int RX_STAT_OVERRUN = 2;
    localparam int RX_STAT_FULL    = 3;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Show-ahead single-clock FIFO. The head entry is visible on 'head' without
// a read; 'pop' advances to the next entry. Pushing while full is only
// accepted when a pop happens in the same clock; a pop while empty is
// ignored.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push, wdata: write request and data
//   pop        : remove head entry
//   full, empty: occupancy flags
//   count      : number of entries held (0..DEPTH)
//   head       : oldest entry (meaningful only when not empty)
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; the separate
    // count is what tells a full FIFO apart from an empty one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_receiver.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_receiver
// Oversampling UART receiver with a show-ahead receive FIFO and sticky
// error flags for the SAP-2 memory-mapped serial port.
// Ports:
//   clk                        : system clock
//   reset                      : asynchronous active-high reset
//   rx_serial_in_data          : asynchronous serial line, idles high
//   rx_read_strobe             : one-clock pulse, pops the FIFO head
//   rx_status_clear            : one-clock pulse, clears sticky error bits
//   rx_parallel_data_out       : FIFO head, zero-extended above DATA_BITS
//   rx_strobe_data_ready_level : high while the FIFO holds data
//   rx_status_reg              : {full, overrun, parity err, frame err}
//   rx_fifo_count              : entries currently held
// Build option:
//   UART_RX_MAJORITY_VOTE_EN   : when defined, every bit is a 2-of-3 vote of
//                                the samples at centre-1, centre, centre+1;
//                                otherwise a single centre sample is used.
// ---------------------------------------------------------------------------
module uart_rx_fifo_receiver
    import uart_pkg::*;
    import arch_defs_pkg::*;
#(
    parameter int CLOCK_SPEED = 2_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_serial_in_data,
    input  logic                          rx_read_strobe,
    input  logic                          rx_status_clear,
    output logic [DATA_WIDTH-1:0]         rx_parallel_data_out,
    output logic                          rx_strobe_data_ready_level,
    output logic [3:0]                    rx_status_reg,
    output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count
);

    localparam int DIV  = CLOCK_SPEED / (BAUD_RATE * OVERSAMPLE);
    localparam int TC_W = $clog2(DIV + 1);
    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS);
    localparam parity_mode_t PMODE = parity_mode_t'(PARITY_MODE[1:0]);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int VOTE_LAG = 1;
`else
    localparam int VOTE_LAG = 0;
`endif

    localparam logic [SC_W-1:0] START_DEC = SC_W'(OVERSAMPLE / 2 - 1 + VOTE_LAG);
    localparam logic [SC_W-1:0] BIT_END   = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(DATA_BITS - 1);

    uart_rx_state_t         state;
    logic                   rx_meta;
    logic                   rx_sync;
    logic                   rx_prev;
    logic                   start_edge;
    logic [TC_W-1:0]        tick_cnt;
    logic                   tick;
    logic [SC_W-1:0]        sample_cnt;
    logic [BC_W-1:0]        bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   parity_flag;
    logic                   parity_exp;
    logic                   bit_val;
    logic                   at_start_dec;
    logic                   at_centre;
    logic                   stop_eval;
    logic                   push;
    logic                   frame_evt;
    logic                   parity_evt;
    logic                   overrun_evt;
    logic [2:0]             new_err;
    logic [2:0]             sticky;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_head;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    // All three reset high so a line that is already idle never looks like
    // a start bit coming out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_serial_in_data;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = (state == IDLE) && rx_prev && !rx_sync;
    assign tick       = (tick_cnt == TC_W'(DIV - 1));

    // Oversample tick divider. Realigned on every start edge so the sample
    // points sit at a fixed offset from the start of each frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (start_edge || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] vote_hist;

    // Keeps the two previous tick samples so the decision taken one tick
    // after the bit centre can vote across centre-1, centre and centre+1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vote_hist <= 2'b11;
        end else if (tick) begin
            vote_hist <= {vote_hist[0], rx_sync};
        end
    end

    assign bit_val = majority3(vote_hist[1], vote_hist[0], rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    assign at_start_dec = tick && (sample_cnt == START_DEC);
    assign at_centre    = tick && (sample_cnt == BIT_END);

    // Parity the received payload should carry for the configured mode.
    always_comb begin
        parity_exp = 1'b0;
        case (PMODE)
            PARITY_EVEN: parity_exp = ^shift_reg;
            PARITY_ODD:  parity_exp = ~^shift_reg;
            default:     parity_exp = 1'b0;
        endcase
    end

    // Frame decoder. The sample counter is cleared at every decision point,
    // so after the start bit each following decision lands one full bit
    // period later, i.e. on the next bit centre.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            parity_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state      <= START;
                        sample_cnt <= '0;
                    end
                end
                START: begin
                    if (at_start_dec) begin
                        sample_cnt  <= '0;
                        bit_cnt     <= '0;
                        parity_flag <= 1'b0;
                        state       <= bit_val ? IDLE : DATA;
                    end else if (tick) begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (at_centre) begin
                        sample_cnt <= '0;
                        shift_reg  <= {bit_val, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state <= (PMODE != PARITY_NONE) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (tick) begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (at_centre) begin
                        sample_cnt  <= '0;
                        parity_flag <= (bit_val != parity_exp);
                        state       <= STOP;
                    end else if (tick) begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (at_centre) begin
                        sample_cnt <= '0;
                        state      <= bit_val ? IDLE : BREAK;
                    end else if (tick) begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Events raised on the stop-bit decision. A push into a full FIFO is only
    // an overrun when the CPU is not popping in the very same clock.
    always_comb begin
        stop_eval   = (state == STOP) && at_centre;
        push        = stop_eval && bit_val;
        frame_evt   = stop_eval && !bit_val;
        parity_evt  = push && parity_flag;
        overrun_evt = push && fifo_full && !rx_read_strobe;
        new_err                  = '0;
        new_err[RX_STAT_FRAME]   = frame_evt;
        new_err[RX_STAT_PARITY]  = parity_evt;
        new_err[RX_STAT_OVERRUN] = overrun_evt;
    end

    // Sticky error bits. The new-error term is OR-ed after the clear so an
    // error arriving in the same clock as a clear is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky <= '0;
        end else begin
            sticky <= (sticky & ~{3{rx_status_clear}}) | new_err;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (shift_reg),
        .pop   (rx_read_strobe),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (rx_fifo_count),
        .head  (fifo_head)
    );

    // CPU-visible view: the data port reads zero whenever nothing is queued,
    // and the full bit is live rather than sticky.
    always_comb begin
        rx_parallel_data_out       = fifo_empty ? '0 : DATA_WIDTH'(fifo_head);
        rx_strobe_data_ready_level = !fifo_empty;
        rx_status_reg              = '0;
        rx_status_reg[RX_STAT_OVERRUN:RX_STAT_FRAME] = sticky;
        rx_status_reg[RX_STAT_FULL]                  = fifo_full;
    end

endmodule
